regfile_pipelined: RTL

REGFILE_PIPELINED -- requirements
Module: regfile_pipelined

---
 rtl/regfile_pipelined.sv | 87 ++++++++
 1 files changed

// File: rtl/regfile_pipelined.sv
// Two-read, one-write register file with optional same-cycle write forwarding,
// optional hardwired zero register and a 0- or 1-cycle read path.
module regfile_pipelined #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int READ_LATENCY = 1,
  parameter int ZERO_REG     = 1,
  parameter int BYPASS       = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic              ctrl_readEnA,
  input  logic              ctrl_readEnB,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  output logic              valid_readA,
  output logic              valid_readB
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  assign wr_ok = ctrl_writeEnable && !(ZERO_REG != 0 && ctrl_writeReg == '0);

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[ctrl_writeReg] <= data_writeReg;
    end
  end

  // Explicit DEPTH:1 mux; forwarding applies before the zero-register override
  always_comb begin
    rd_a = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ctrl_readRegA == ADDR_W'(i)) rd_a = mem[i];
    if (BYPASS != 0 && ctrl_writeEnable && ctrl_writeReg == ctrl_readRegA)
      rd_a = data_writeReg;
    if (ZERO_REG != 0 && ctrl_readRegA == '0)
      rd_a = '0;
  end

  always_comb begin
    rd_b = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ctrl_readRegB == ADDR_W'(i)) rd_b = mem[i];
    if (BYPASS != 0 && ctrl_writeEnable && ctrl_writeReg == ctrl_readRegB)
      rd_b = data_writeReg;
    if (ZERO_REG != 0 && ctrl_readRegB == '0)
      rd_b = '0;
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      // Reset gates the outputs so they read zero even while a write is forwarded
      assign data_readRegA = ctrl_reset ? rd_a : '0;
      assign data_readRegB = ctrl_reset ? rd_b : '0;
      assign valid_readA   = ctrl_readEnA & ctrl_reset;
      assign valid_readB   = ctrl_readEnB & ctrl_reset;
    end else begin : g_reg_read
      always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
          data_readRegA <= '0;
          data_readRegB <= '0;
          valid_readA   <= 1'b0;
          valid_readB   <= 1'b0;
        end else begin
          valid_readA <= ctrl_readEnA;
          valid_readB <= ctrl_readEnB;
          if (ctrl_readEnA) data_readRegA <= rd_a;
          if (ctrl_readEnB) data_readRegB <= rd_b;
        end
      end
    end
  endgenerate

endmodule
